cve2_wb_queue: RTL and testbench

//  Multi-entry in-order writeback stage placed between ID/EX and the register file.

---
 rtl/cve2_pkg.sv | 29 ++
 rtl/cve2_wb_fwd_match.sv | 56 +++++
 rtl/cve2_wb_queue.sv | 175 +++++++++++++++++
 tb/tb_cve2_wb_queue.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cve2_pkg.sv
//------------------------------------------------------------------------------
// cve2_pkg : shared types for the writeback queue slice.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cve2_pkg;

  localparam int unsigned WbQueueMaxDepth = 8;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'b00,
    WB_INSTR_STORE = 2'b01,
    WB_INSTR_OTHER = 2'b10
  } wb_instr_type_e;

  typedef struct packed {
    logic           we;
    logic [4:0]     waddr;
    logic [31:0]    wdata;
    wb_instr_type_e itype;
    logic [31:0]    pc;
    logic           compressed;
    logic           count;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/cve2_wb_fwd_match.sv
//------------------------------------------------------------------------------
// cve2_wb_fwd_match : youngest-first forwarding lookup of one read address.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cve2_wb_fwd_match #(
  parameter int unsigned Depth = 2,
  parameter int unsigned PtrW  = 1
) (
  input  logic [4:0]       raddr_i,
  input  logic [PtrW-1:0]  head_i,
  input  logic [Depth-1:0] valid_i,
  input  logic [Depth-1:0] we_i,
  input  logic [Depth-1:0] is_load_i,
  input  logic [Depth-1:0] is_other_i,
  input  logic [4:0]       waddr_i [Depth],
  input  logic [31:0]      wdata_i [Depth],
  output logic             fwd_valid_o,
  output logic [31:0]      fwd_data_o,
  output logic             fwd_stall_o
);

  logic            found;
  logic [PtrW-1:0] idx;
  int              pos;

  // Valid entries are contiguous from the head, so walking age offsets from
  // Depth-1 down to 0 visits valid entries youngest first.
  always_comb begin
    fwd_valid_o = 1'b0;
    fwd_data_o  = '0;
    fwd_stall_o = 1'b0;
    found       = 1'b0;
    idx         = '0;
    pos         = 0;
    for (int k = int'(Depth) - 1; k >= 0; k--) begin
      pos = int'(head_i) + k;
      if (pos >= int'(Depth)) pos = pos - int'(Depth);
      idx = PtrW'(pos);
      if (!found && valid_i[idx] && (raddr_i != 5'd0) && (waddr_i[idx] == raddr_i) &&
          (we_i[idx] || is_load_i[idx])) begin
        found = 1'b1;
        if (is_load_i[idx]) begin
          fwd_stall_o = 1'b1;
        end else if (is_other_i[idx]) begin
          fwd_valid_o = 1'b1;
          fwd_data_o  = wdata_i[idx];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cve2_wb_queue.sv
//------------------------------------------------------------------------------
// cve2_wb_queue : in-order multi-entry writeback queue with RF forwarding.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cve2_wb_queue
  import cve2_pkg::*;
#(
  parameter int unsigned Depth    = 2,
  parameter bit          ResetAll = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_wb_i,
  input  wb_instr_type_e instr_type_wb_i,
  input  logic [31:0]    pc_id_i,
  input  logic           instr_is_compressed_id_i,
  input  logic           instr_perf_count_id_i,
  input  logic [4:0]     rf_waddr_id_i,
  input  logic [31:0]    rf_wdata_id_i,
  input  logic           rf_we_id_i,
  input  logic [31:0]    rf_wdata_lsu_i,
  input  logic           rf_we_lsu_i,
  input  logic           lsu_resp_valid_i,
  input  logic           lsu_resp_err_i,
  input  logic [4:0]     rf_raddr_a_i,
  input  logic [4:0]     rf_raddr_b_i,
  output logic           ready_wb_o,
  output logic [4:0]     rf_waddr_wb_o,
  output logic [31:0]    rf_wdata_wb_o,
  output logic           rf_we_wb_o,
  output logic           fwd_valid_a_o,
  output logic [31:0]    fwd_data_a_o,
  output logic           fwd_stall_a_o,
  output logic           fwd_valid_b_o,
  output logic [31:0]    fwd_data_b_o,
  output logic           fwd_stall_b_o,
  output logic           outstanding_load_wb_o,
  output logic           outstanding_store_wb_o,
  output logic [31:0]    pc_wb_o,
  output logic           instr_done_wb_o,
  output logic           perf_instr_ret_wb_o,
  output logic           perf_instr_ret_compressed_wb_o,
  output logic [2:0]     perf_instr_ret_wb_spec_o,
  output logic [2:0]     perf_instr_ret_compressed_wb_spec_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);

  wb_entry_t        entries_q [Depth];
  logic [Depth-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;

  wb_entry_t  head_entry, new_entry;
  logic       head_valid, head_other, head_done, accept, id_we;
  logic [3:0] spec_cnt, spec_cnt_c;

  logic [Depth-1:0] ent_we, ent_load, ent_store, ent_other;
  logic [4:0]       ent_waddr [Depth];
  logic [31:0]      ent_wdata [Depth];

  assign head_entry = entries_q[head_q];
  assign head_valid = valid_q[head_q];
  assign head_other = (head_entry.itype == WB_INSTR_OTHER);
  assign head_done  = head_other | lsu_resp_valid_i;

  assign instr_done_wb_o = head_valid & head_done;
  assign ready_wb_o      = (count_q < CntW'(Depth)) | instr_done_wb_o;
  assign accept          = en_wb_i & ready_wb_o;

  assign new_entry = '{we: rf_we_id_i, waddr: rf_waddr_id_i, wdata: rf_wdata_id_i,
                       itype: instr_type_wb_i, pc: pc_id_i,
                       compressed: instr_is_compressed_id_i,
                       count: instr_perf_count_id_i};

  // Retire clears before enqueue sets, so a full-queue swap keeps the slot valid.
  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (instr_done_wb_o) begin
      valid_d[head_q] = 1'b0;
      head_d          = (head_q == LastIdx) ? '0 : head_q + 1'b1;
    end
    if (accept) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = (tail_q == LastIdx) ? '0 : tail_q + 1'b1;
    end
    count_d = count_q + CntW'(accept) - CntW'(instr_done_wb_o);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  if (ResetAll) begin : g_payload_rst
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < int'(Depth); i++) entries_q[i] <= '0;
      end else if (accept) begin
        entries_q[tail_q] <= new_entry;
      end
    end
  end else begin : g_payload_norst
    always_ff @(posedge clk_i) begin
      if (accept) entries_q[tail_q] <= new_entry;
    end
  end

  assign id_we          = head_valid & head_other & head_entry.we;
  assign rf_we_wb_o     = id_we | rf_we_lsu_i;
  assign rf_wdata_wb_o  = ({32{id_we}} & head_entry.wdata) | ({32{rf_we_lsu_i}} & rf_wdata_lsu_i);
  assign rf_waddr_wb_o  = head_valid ? head_entry.waddr : 5'd0;
  assign pc_wb_o        = head_valid ? head_entry.pc : 32'd0;

  assign perf_instr_ret_wb_o = instr_done_wb_o & head_entry.count &
                               ~(lsu_resp_valid_i & lsu_resp_err_i);
  assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head_entry.compressed;

  always_comb begin
    spec_cnt   = '0;
    spec_cnt_c = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      ent_we[i]    = entries_q[i].we;
      ent_load[i]  = valid_q[i] & (entries_q[i].itype == WB_INSTR_LOAD);
      ent_store[i] = valid_q[i] & (entries_q[i].itype == WB_INSTR_STORE);
      ent_other[i] = (entries_q[i].itype == WB_INSTR_OTHER);
      ent_waddr[i] = entries_q[i].waddr;
      ent_wdata[i] = entries_q[i].wdata;
      spec_cnt   = spec_cnt + 4'(valid_q[i] & entries_q[i].count);
      spec_cnt_c = spec_cnt_c + 4'(valid_q[i] & entries_q[i].count & entries_q[i].compressed);
    end
  end

  assign outstanding_load_wb_o  = |ent_load;
  assign outstanding_store_wb_o = |ent_store;
  assign perf_instr_ret_wb_spec_o            = spec_cnt[3] ? 3'd7 : spec_cnt[2:0];
  assign perf_instr_ret_compressed_wb_spec_o = spec_cnt_c[3] ? 3'd7 : spec_cnt_c[2:0];

  cve2_wb_fwd_match #(.Depth(Depth), .PtrW(PtrW)) u_fwd_a (
    .raddr_i(rf_raddr_a_i), .head_i(head_q), .valid_i(valid_q), .we_i(ent_we),
    .is_load_i(ent_load), .is_other_i(ent_other), .waddr_i(ent_waddr), .wdata_i(ent_wdata),
    .fwd_valid_o(fwd_valid_a_o), .fwd_data_o(fwd_data_a_o), .fwd_stall_o(fwd_stall_a_o)
  );

  cve2_wb_fwd_match #(.Depth(Depth), .PtrW(PtrW)) u_fwd_b (
    .raddr_i(rf_raddr_b_i), .head_i(head_q), .valid_i(valid_q), .we_i(ent_we),
    .is_load_i(ent_load), .is_other_i(ent_other), .waddr_i(ent_waddr), .wdata_i(ent_wdata),
    .fwd_valid_o(fwd_valid_b_o), .fwd_data_o(fwd_data_b_o), .fwd_stall_o(fwd_stall_b_o)
  );

  a_depth_legal: assert property (@(posedge clk_i) (Depth >= 1) && (Depth <= WbQueueMaxDepth));
  a_rf_src_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
                                    $onehot0({id_we, rf_we_lsu_i}));
  a_resp_needs_lsu_head: assert property (@(posedge clk_i) disable iff (rst_i)
                                          lsu_resp_valid_i |-> (head_valid & ~head_other));

endmodule

`default_nettype wire

// File: tb/tb_cve2_wb_queue.sv
//------------------------------------------------------------------------------
// tb_cve2_wb_queue : directed bench for the writeback queue (Depth 3 and 2).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cve2_wb_queue;
  import cve2_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, en, en2, comp, pcnt, we, lsu_we, resp_v, resp_err;
  wb_instr_type_e itype;
  logic [31:0]    pc, wdata, lsu_wdata;
  logic [4:0]     waddr, ra, rb;

  logic        ready, rf_we, fva, fsa, fvb, fsb, oload, ostore, done, pret, pretc;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, fda, fdb, pc_wb;
  logic [2:0]  spec, specc;

  logic        d2_ready, d2_rf_we, d2_fva, d2_fsa, d2_fvb, d2_fsb, d2_oload, d2_ostore;
  logic        d2_done, d2_pret, d2_pretc;
  logic [4:0]  d2_rf_waddr;
  logic [31:0] d2_rf_wdata, d2_fda, d2_fdb, d2_pc_wb;
  logic [2:0]  d2_spec, d2_specc;

  int n_checks = 0;
  int n_fail   = 0;

  cve2_wb_queue #(.Depth(3), .ResetAll(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst), .en_wb_i(en), .instr_type_wb_i(itype), .pc_id_i(pc),
    .instr_is_compressed_id_i(comp), .instr_perf_count_id_i(pcnt), .rf_waddr_id_i(waddr),
    .rf_wdata_id_i(wdata), .rf_we_id_i(we), .rf_wdata_lsu_i(lsu_wdata), .rf_we_lsu_i(lsu_we),
    .lsu_resp_valid_i(resp_v), .lsu_resp_err_i(resp_err), .rf_raddr_a_i(ra), .rf_raddr_b_i(rb),
    .ready_wb_o(ready), .rf_waddr_wb_o(rf_waddr), .rf_wdata_wb_o(rf_wdata), .rf_we_wb_o(rf_we),
    .fwd_valid_a_o(fva), .fwd_data_a_o(fda), .fwd_stall_a_o(fsa),
    .fwd_valid_b_o(fvb), .fwd_data_b_o(fdb), .fwd_stall_b_o(fsb),
    .outstanding_load_wb_o(oload), .outstanding_store_wb_o(ostore), .pc_wb_o(pc_wb),
    .instr_done_wb_o(done), .perf_instr_ret_wb_o(pret), .perf_instr_ret_compressed_wb_o(pretc),
    .perf_instr_ret_wb_spec_o(spec), .perf_instr_ret_compressed_wb_spec_o(specc)
  );

  // Second instance only sees OTHER offers; its LSU inputs stay idle.
  cve2_wb_queue #(.Depth(2), .ResetAll(1'b1)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .en_wb_i(en2), .instr_type_wb_i(itype), .pc_id_i(pc),
    .instr_is_compressed_id_i(comp), .instr_perf_count_id_i(pcnt), .rf_waddr_id_i(waddr),
    .rf_wdata_id_i(wdata), .rf_we_id_i(we), .rf_wdata_lsu_i(32'd0), .rf_we_lsu_i(1'b0),
    .lsu_resp_valid_i(1'b0), .lsu_resp_err_i(1'b0), .rf_raddr_a_i(ra), .rf_raddr_b_i(rb),
    .ready_wb_o(d2_ready), .rf_waddr_wb_o(d2_rf_waddr), .rf_wdata_wb_o(d2_rf_wdata),
    .rf_we_wb_o(d2_rf_we), .fwd_valid_a_o(d2_fva), .fwd_data_a_o(d2_fda), .fwd_stall_a_o(d2_fsa),
    .fwd_valid_b_o(d2_fvb), .fwd_data_b_o(d2_fdb), .fwd_stall_b_o(d2_fsb),
    .outstanding_load_wb_o(d2_oload), .outstanding_store_wb_o(d2_ostore), .pc_wb_o(d2_pc_wb),
    .instr_done_wb_o(d2_done), .perf_instr_ret_wb_o(d2_pret),
    .perf_instr_ret_compressed_wb_o(d2_pretc), .perf_instr_ret_wb_spec_o(d2_spec),
    .perf_instr_ret_compressed_wb_spec_o(d2_specc)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic offer(input wb_instr_type_e t, input logic [4:0] a, input logic [31:0] d,
                       input logic w, input logic [31:0] p, input logic c);
    en = 1'b1; itype = t; waddr = a; wdata = d; we = w; pc = p; comp = c; pcnt = 1'b1;
  endtask

  task automatic idle();
    en = 1'b0; en2 = 1'b0; resp_v = 1'b0; resp_err = 1'b0; lsu_we = 1'b0; lsu_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; idle(); itype = WB_INSTR_OTHER; pc = '0; comp = 1'b0; pcnt = 1'b0;
    waddr = '0; wdata = '0; we = 1'b0; ra = '0; rb = '0;
    tick(); tick();
    rst = 1'b0; settle();

    // reset state on both depths
    chk("rst_ready", ready, 1);        chk("rst_d2_ready", d2_ready, 1);
    chk("rst_rf_we", rf_we, 0);        chk("rst_d2_rf_we", d2_rf_we, 0);
    chk("rst_d2_waddr", d2_rf_waddr, 0); chk("rst_d2_wdata", d2_rf_wdata, 0);
    chk("rst_d2_pc", d2_pc_wb, 0);     chk("rst_d2_done", d2_done, 0);
    chk("rst_d2_oload", d2_oload, 0);  chk("rst_d2_spec", d2_spec, 0);

    // test 1: OTHER x5=0x11 written one cycle after accept
    offer(WB_INSTR_OTHER, 5'd5, 32'h11, 1'b1, 32'h100, 1'b1); en2 = 1'b1;
    tick(); idle(); settle();
    chk("t1_we", d2_rf_we, 1);       chk("t1_waddr", d2_rf_waddr, 5);
    chk("t1_wdata", d2_rf_wdata, 32'h11);
    chk("t1_pret", d2_pret, 1);      chk("t1_pretc", d2_pretc, 1);
    chk("t1_spec", d2_spec, 1);      chk("t1_d3_we", rf_we, 1);
    tick(); settle();
    chk("t1_empty_we", d2_rf_we, 0);

    // test 2: LOAD x3, STORE, OTHER x4 with Depth 3 and no responses
    offer(WB_INSTR_LOAD, 5'd3, 32'h0, 1'b1, 32'h200, 1'b0); settle();
    chk("t2_ready0", ready, 1); tick();
    offer(WB_INSTR_STORE, 5'd0, 32'h0, 1'b0, 32'h204, 1'b0); settle();
    chk("t2_ready1", ready, 1); tick();
    offer(WB_INSTR_OTHER, 5'd4, 32'hAA, 1'b1, 32'h208, 1'b1); settle();
    chk("t2_ready2", ready, 1); tick();
    idle(); ra = 5'd4; rb = 5'd3; settle();
    chk("t2_full", ready, 0);   chk("t2_oload", oload, 1);   chk("t2_ostore", ostore, 1);
    chk("t2_no_we", rf_we, 0);  chk("t2_pc", pc_wb, 32'h200); chk("t2_spec", spec, 3);
    chk("t2_specc", specc, 1);  chk("t2_fva", fva, 1);        chk("t2_fda", fda, 32'hAA);
    chk("t2_fsb", fsb, 1);      chk("t2_fvb", fvb, 0);
    tick(); settle();
    chk("t2_idle_we", rf_we, 0);
    resp_v = 1'b1; lsu_we = 1'b1; lsu_wdata = 32'hDEAD; settle();
    chk("t2_r1_done", done, 1); chk("t2_r1_we", rf_we, 1);
    chk("t2_r1_waddr", rf_waddr, 3); chk("t2_r1_wdata", rf_wdata, 32'hDEAD);
    tick();
    lsu_we = 1'b0; lsu_wdata = '0; settle();
    chk("t2_r2_done", done, 1); chk("t2_r2_we", rf_we, 0); chk("t2_r2_pc", pc_wb, 32'h204);
    tick(); idle(); settle();
    chk("t2_x4_we", rf_we, 1); chk("t2_x4_waddr", rf_waddr, 4);
    chk("t2_x4_wdata", rf_wdata, 32'hAA);
    tick(); settle();
    chk("t2_drained", ready, 1); chk("t2_oload_clr", oload, 0);

    // test 5: erroring load response retires without a perf pulse
    offer(WB_INSTR_LOAD, 5'd6, 32'h0, 1'b1, 32'h400, 1'b0); tick();
    idle(); resp_v = 1'b1; resp_err = 1'b1; settle();
    chk("t5_done", done, 1); chk("t5_pret", pret, 0);
    tick(); idle(); settle();
    chk("t5_empty_done", done, 0);

    // test 3: five accepts so far, so the stores fill slots 2,0,1 and the swap wraps tail to 0
    offer(WB_INSTR_STORE, 5'd0, 32'h0, 1'b0, 32'h500, 1'b0); tick();
    offer(WB_INSTR_STORE, 5'd0, 32'h0, 1'b0, 32'h504, 1'b0); tick();
    offer(WB_INSTR_STORE, 5'd0, 32'h0, 1'b0, 32'h508, 1'b0); tick();
    idle(); settle();
    chk("t3_full", ready, 0);
    offer(WB_INSTR_OTHER, 5'd9, 32'h99, 1'b1, 32'h50C, 1'b0); resp_v = 1'b1; settle();
    chk("t3_swap_ready", ready, 1); chk("t3_swap_done", done, 1);
    tick(); idle(); settle();
    chk("t3_still_full", ready, 0); chk("t3_head_pc", pc_wb, 32'h504); chk("t3_spec", spec, 3);
    resp_v = 1'b1; tick(); tick(); idle(); settle();
    chk("t3_x9_we", rf_we, 1); chk("t3_x9_waddr", rf_waddr, 9);
    chk("t3_x9_wdata", rf_wdata, 32'h99); chk("t3_x9_pc", pc_wb, 32'h50C);
    tick(); settle();
    chk("t3_drained", ready, 1);

    // test 4: youngest writer of x7 is a pending load
    offer(WB_INSTR_STORE, 5'd0, 32'h0, 1'b0, 32'h700, 1'b0); tick();
    offer(WB_INSTR_OTHER, 5'd7, 32'h1, 1'b1, 32'h704, 1'b0); tick();
    idle(); ra = 5'd7; settle();
    chk("t4_fwd_valid", fva, 1); chk("t4_fwd_data", fda, 32'h1);
    offer(WB_INSTR_LOAD, 5'd7, 32'h0, 1'b1, 32'h708, 1'b0); tick();
    idle(); settle();
    chk("t4_stall", fsa, 1); chk("t4_no_valid", fva, 0);
    resp_v = 1'b1; tick(); idle(); tick();
    resp_v = 1'b1; lsu_we = 1'b1; lsu_wdata = 32'h77; tick(); idle(); settle();
    chk("t4_after_valid", fva, 0); chk("t4_after_stall", fsa, 0);

    // test 6: reset with two entries pending and a response in the reset cycle
    offer(WB_INSTR_STORE, 5'd0, 32'h0, 1'b0, 32'h800, 1'b0); tick();
    offer(WB_INSTR_OTHER, 5'd0, 32'h5, 1'b1, 32'h804, 1'b0); tick();
    idle(); ra = 5'd0; rb = 5'd0; settle();
    chk("t6_x0_fwd_a", fva, 0); chk("t6_x0_fwd_b", fvb, 0);
    rst = 1'b1; resp_v = 1'b1; tick();
    rst = 1'b0; idle(); settle();
    chk("t6_ready", ready, 1); chk("t6_we", rf_we, 0); chk("t6_done", done, 0);
    chk("t6_ostore", ostore, 0); chk("t6_pc", pc_wb, 0); chk("t6_spec", spec, 0);
    tick(); settle();
    chk("t6_we_later", rf_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
